// File: rtl/buf_drain_ctrl.sv
// buf_drain_ctrl: read-side controller for a single-port RGB frame buffer.
// Hands the fill window to the writer, waits for a fresh full flag, scans the
// buffer in address order and streams the pixels over valid/ready through a
// 2-entry skid FIFO, then re-opens the fill window.
module buf_drain_ctrl #(
   parameter int unsigned DEPTH = 10000,
   parameter int unsigned AW    = 20
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          buf_full,
   output logic          re,
   output logic [AW-1:0] rd_addr,
   output logic          rd_own,
   input  logic [7:0]    r_in,
   input  logic [7:0]    g_in,
   input  logic [7:0]    b_in,
   output logic          buf_empty,
   output logic          pix_valid,
   input  logic          pix_ready,
   output logic [23:0]   pix_data,
   output logic          pix_last,
   output logic          frame_done
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   typedef enum logic [1:0] {
      FILL,
      DRAIN,
      FLUSH
   } state_t;

   state_t        state, state_nxt;
   logic          full_q;
   logic          inflight;
   logic          inflight_last;
   logic [AW-1:0] issue_ptr;
   logic          launch;

   logic [23:0]   fifo_data [2];
   logic          fifo_last [2];
   logic          wr_ptr, rd_ptr;
   logic [1:0]    count;
   logic          pop;
   logic [2:0]    occ;

   assign pix_valid  = (count != 2'd0);
   assign pop        = pix_valid & pix_ready;
   assign pix_data   = fifo_data[rd_ptr];
   assign pix_last   = pix_valid & fifo_last[rd_ptr];
   assign frame_done = pop & fifo_last[rd_ptr];
   assign rd_addr    = issue_ptr;

   // Words committed after this cycle's pop; the pop credit lets a steady
   // ready stream sustain one pixel per cycle without overfilling the FIFO.
   assign occ = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

   // Next-state, buffer-side controls and fill-start detection
   always_comb begin
      state_nxt = state;
      re        = 1'b0;
      rd_own    = 1'b0;
      buf_empty = 1'b0;
      launch    = 1'b0;
      case (state)
         FILL: begin
            buf_empty = 1'b1;
            if (buf_full && !full_q) begin
               launch    = 1'b1;
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            rd_own = 1'b1;
            if (occ < 3'd2) begin
               re = 1'b1;
               if (issue_ptr == LAST_ADDR) state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            rd_own = inflight;
            if (frame_done) state_nxt = FILL;
         end
         default: state_nxt = FILL;
      endcase
   end

   // State, full-flag edge register and read issue tracking
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= FILL;
         full_q        <= 1'b1;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         issue_ptr     <= '0;
      end else begin
         state         <= state_nxt;
         full_q        <= buf_full;
         inflight      <= re;
         inflight_last <= re & (issue_ptr == LAST_ADDR);
         if (launch)
            issue_ptr <= '0;
         else if (re && issue_ptr != LAST_ADDR)
            issue_ptr <= issue_ptr + 1'b1;
      end
   end

   // Output FIFO: capture returned words with their last tag, pop on handshake
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         fifo_last[0] <= 1'b0;
         fifo_last[1] <= 1'b0;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         count        <= 2'd0;
      end else begin
         if (inflight) begin
            fifo_data[wr_ptr] <= {b_in, g_in, r_in};
            fifo_last[wr_ptr] <= inflight_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, inflight} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_buf_drain_ctrl.sv
// Testbench for buf_drain_ctrl: frame-level pixel queue model plus a word-per-
// address buffer model, checked every cycle, with directed scenarios.
module tb_buf_drain_ctrl;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 20;

   logic          clk = 1'b0;
   logic          reset;
   logic          buf_full;
   logic          re;
   logic [AW-1:0] rd_addr;
   logic          rd_own;
   logic [7:0]    r_in, g_in, b_in;
   logic          buf_empty;
   logic          pix_valid;
   logic          pix_ready;
   logic [23:0]   pix_data;
   logic          pix_last;
   logic          frame_done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   buf_drain_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .reset(reset), .buf_full(buf_full),
      .re(re), .rd_addr(rd_addr), .rd_own(rd_own),
      .r_in(r_in), .g_in(g_in), .b_in(b_in),
      .buf_empty(buf_empty), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_data(pix_data), .pix_last(pix_last), .frame_done(frame_done)
   );

   function automatic logic [23:0] word_of(int unsigned a);
      logic [31:0] w;
      w = a * 32'h0001_0203;
      return w[23:0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc++;

   // Buffer model: the word for an address read in one cycle appears the next.
   logic          pend_v = 1'b0;
   logic [AW-1:0] pend_a = '0;
   always @(negedge clk) begin
      pend_v = re;
      pend_a = rd_addr;
   end
   always @(posedge clk) begin
      logic [23:0] w;
      #1;
      if (pend_v) w = word_of(int'(pend_a));
      else        w = 24'($urandom);
      r_in = w[7:0];
      g_in = w[15:8];
      b_in = w[23:16];
   end

   // pix_ready driver: 0 = held high, 1 = random, 2 = held low
   int ready_mode = 0;
   always @(posedge clk) begin
      #2;
      case (ready_mode)
         1:       pix_ready = 1'($urandom_range(0, 1));
         2:       pix_ready = 1'b0;
         default: pix_ready = 1'b1;
      endcase
   end

   // Frame model: a fresh full edge seen while filling queues the whole frame.
   typedef struct packed {
      logic        last;
      logic [23:0] data;
   } px_t;
   px_t         exp_q[$];
   bit          m_fill   = 1'b1;
   bit          prev_full = 1'b1;
   int          next_addr = 0;
   int          issued = 0, accepted = 0;
   bit          re_prev = 1'b0;
   bit          hold_v = 1'b0;
   logic [23:0] hold_d;
   logic        hold_l;
   int          pix_cnt = 0, done_cnt = 0;
   int          start_cyc = 0, first_v_cyc = -1, done_cyc = 0;
   logic [23:0] last_px = '0;
   logic [23:0] px5 = '0;

   always @(negedge clk) begin
      bit acc;
      if (reset) begin
         check("rst_re", re, 0);
         check("rst_rd_own", rd_own, 0);
         check("rst_rd_addr", rd_addr, 0);
         check("rst_buf_empty", buf_empty, 1);
         check("rst_pix_valid", pix_valid, 0);
         check("rst_pix_data", pix_data, 0);
         check("rst_pix_last", pix_last, 0);
         check("rst_frame_done", frame_done, 0);
         exp_q.delete();
         m_fill = 1'b1; prev_full = 1'b1; next_addr = 0;
         issued = 0; accepted = 0; re_prev = 1'b0; hold_v = 1'b0;
      end else begin
         acc = pix_valid && pix_ready;
         check("buf_empty", buf_empty, m_fill);
         check("rd_own", rd_own, !m_fill && (next_addr < int'(DEPTH) || re_prev));
         if (re) begin
            check("re_while_fill", m_fill, 0);
            check("rd_addr", rd_addr, next_addr);
            check("outstanding_le_2", (issued + 1 - accepted - int'(acc)) <= 2, 1);
         end
         if (hold_v) begin
            check("stall_data_hold", pix_data, hold_d);
            check("stall_last_hold", pix_last, hold_l);
         end
         if (pix_valid) begin
            if (first_v_cyc < 0) first_v_cyc = cyc;
            if (exp_q.size() == 0) begin
               check("spurious_pixel", pix_valid, 0);
            end else begin
               check("pix_data", pix_data, exp_q[0].data);
               check("pix_last", pix_last, exp_q[0].last);
               if (pix_ready) begin
                  check("frame_done", frame_done, exp_q[0].last);
                  if (accepted == 5) px5 = pix_data;
                  if (exp_q[0].last) begin
                     m_fill   = 1'b1;
                     done_cnt++;
                     done_cyc = cyc;
                     last_px  = pix_data;
                  end
                  void'(exp_q.pop_front());
                  pix_cnt++;
                  accepted++;
               end else begin
                  check("frame_done_stalled", frame_done, 0);
               end
            end
         end else begin
            check("frame_done_idle", frame_done, 0);
         end
         hold_v = pix_valid && !pix_ready;
         hold_d = pix_data;
         hold_l = pix_last;
         if (re) begin
            issued++;
            next_addr++;
         end
         re_prev = re;
         if (m_fill && buf_full && !prev_full) begin
            for (int a = 0; a < int'(DEPTH); a++)
               exp_q.push_back('{last: (a == int'(DEPTH) - 1), data: word_of(a)});
            m_fill = 1'b0; next_addr = 0; issued = 0; accepted = 0;
            start_cyc = cyc; first_v_cyc = -1;
         end
         prev_full = buf_full;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string name, input int budget);
      int snap;
      int n;
      snap = done_cnt;
      n = 0;
      while (done_cnt == snap && n < budget) begin
         tick(1);
         n++;
      end
      check(name, done_cnt > snap, 1);
   endtask

   task automatic wait_pix(input string name, input int target, input int budget);
      int n;
      n = 0;
      while (pix_cnt < target && n < budget) begin
         tick(1);
         n++;
      end
      check(name, pix_cnt >= target, 1);
   endtask

   initial begin
      int base;
      int dbase;
      reset = 1'b1; buf_full = 1'b0; pix_ready = 1'b1;
      r_in = '0; g_in = '0; b_in = '0;
      tick(3);
      reset = 1'b0;
      tick(2);

      // 1: single frame with pix_ready held high
      base = pix_cnt;
      buf_full = 1'b1;
      wait_done("t1_timeout", 80);
      check("t1_first_valid_latency", first_v_cyc - start_cyc, 3);
      check("t1_back_to_back", done_cyc - first_v_cyc, 15);
      check("t1_pixel_count", pix_cnt - base, 16);
      check("t1_pixel5", px5, 24'h050A0F);
      check("t1_last_pixel", last_px, 24'h0F1E2D);
      check("t1_buf_empty_after", buf_empty, 1);

      // 2: random downstream backpressure
      buf_full = 1'b0;
      tick(3);
      ready_mode = 1;
      base = pix_cnt;
      buf_full = 1'b1;
      wait_done("t2_timeout", 400);
      check("t2_pixel_count", pix_cnt - base, 16);
      ready_mode = 0;

      // 3: ten-cycle stall mid-frame
      buf_full = 1'b0;
      tick(3);
      base = pix_cnt;
      buf_full = 1'b1;
      wait_pix("t3_reach_5", base + 5, 60);
      ready_mode = 2;
      tick(1);
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (i >= 3) begin
            check("t3_re_stalled", re, 0);
            check("t3_valid_stalled", pix_valid, 1);
         end
      end
      ready_mode = 0;
      wait_done("t3_timeout", 80);
      check("t3_pixel_count", pix_cnt - base, 16);

      // 4: flag held high through reset release must not start a drain
      base = done_cnt;
      buf_full = 1'b1;
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(10);
      check("t4_no_start_empty", buf_empty, 1);
      check("t4_no_start_own", rd_own, 0);
      check("t4_no_frame", done_cnt, base);
      buf_full = 1'b0;
      tick(2);
      base = pix_cnt;
      buf_full = 1'b1;
      wait_done("t4_timeout", 80);
      check("t4_pixel_count", pix_cnt - base, 16);

      // 5: reset in the middle of a frame, then restart from address 0
      buf_full = 1'b0;
      tick(3);
      base = pix_cnt;
      buf_full = 1'b1;
      wait_pix("t5_reach_7", base + 7, 60);
      reset = 1'b1;
      #1;
      check("t5_imm_re", re, 0);
      check("t5_imm_rd_own", rd_own, 0);
      check("t5_imm_valid", pix_valid, 0);
      check("t5_imm_buf_empty", buf_empty, 1);
      check("t5_imm_pix_data", pix_data, 0);
      check("t5_imm_pix_last", pix_last, 0);
      check("t5_imm_frame_done", frame_done, 0);
      tick(2);
      reset = 1'b0;
      buf_full = 1'b0;
      tick(2);
      base = pix_cnt;
      buf_full = 1'b1;
      tick(1);
      check("t5_restart_re", re, 1);
      check("t5_restart_addr", rd_addr, 0);
      wait_done("t5_timeout", 80);
      check("t5_pixel_count", pix_cnt - base, 16);

      // 6: extra full edge during the drain is ignored
      buf_full = 1'b0;
      tick(3);
      base = pix_cnt;
      dbase = done_cnt;
      buf_full = 1'b1;
      tick(5);
      buf_full = 1'b0;
      tick(1);
      buf_full = 1'b1;
      wait_done("t6_timeout", 80);
      tick(30);
      check("t6_one_frame_done", done_cnt - dbase, 1);
      check("t6_pixel_count", pix_cnt - base, 16);
      check("t6_idle_after", buf_empty, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
